// File: rtl/fp_convert_seq.sv
// Multi-cycle two's-complement integer to compact float (sign, exponent, significand) converter.
// Build option: define FPCVT_ROUND_EN for round-half-up; otherwise the ROUND state truncates.
module fp_convert_seq #(
  parameter int IN_W   = 12,
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [EXP_W-1:0]  exponent,
  output logic [MANT_W-1:0] significand
);

  localparam int                EMAX    = IN_W - MANT_W - 1;
  localparam logic [EXP_W-1:0]  EMAX_E  = EXP_W'(EMAX);
  localparam logic [EXP_W-1:0]  E_ONE   = EXP_W'(1);
  localparam logic [MANT_W-1:0] F_ONE   = MANT_W'(1);
  localparam logic [MANT_W-1:0] F_HALF  = MANT_W'(1) << (MANT_W - 1);
  localparam logic [IN_W-2:0]   MAG_ONE = (IN_W-1)'(1);
  localparam logic [IN_W-1:0]   DIN_MIN = {1'b1, {(IN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAG   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [IN_W-1:0]   din_r;
  logic [IN_W-2:0]   mag;     // |din| always fits in IN_W-1 bits after saturation
  logic [EXP_W-1:0]  e_cnt;
  logic              sign_r;
  logic              norm_shift;
  logic [MANT_W-1:0] f_trunc;
  logic [MANT_W-1:0] f_rnd;
  logic [EXP_W-1:0]  e_rnd;

  assign norm_shift = (e_cnt != '0) && !mag[IN_W-2];
  assign f_trunc    = mag[IN_W-2 -: MANT_W];

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // out_valid and the result stay put until that edge, in_ready is high only in IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = MAG;
      end
      MAG:  state_nx = NORM;
      NORM: if (!norm_shift) state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef FPCVT_ROUND_EN
  logic rb;
  assign rb = mag[IN_W-2-MANT_W];
`endif

  always_comb begin
    f_rnd = f_trunc;
    e_rnd = e_cnt;
`ifdef FPCVT_ROUND_EN
    if (rb) begin
      if (&f_trunc) begin
        // Carry out of the significand bumps the exponent unless it is already at the top.
        if (e_cnt == EMAX_E) begin
          f_rnd = '1;
        end else begin
          f_rnd = F_HALF;
          e_rnd = e_cnt + E_ONE;
        end
      end else begin
        f_rnd = f_trunc + F_ONE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_r       <= '0;
      mag         <= '0;
      e_cnt       <= '0;
      sign_r      <= 1'b0;
      sign        <= 1'b0;
      exponent    <= '0;
      significand <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) din_r <= din;
        MAG: begin
          sign_r <= din_r[IN_W-1];
          e_cnt  <= EMAX_E;
          if (din_r == DIN_MIN)   mag <= '1;
          else if (din_r[IN_W-1]) mag <= ~din_r[IN_W-2:0] + MAG_ONE;
          else                    mag <= din_r[IN_W-2:0];
        end
        NORM: begin
          if (norm_shift) begin
            mag   <= mag << 1;
            e_cnt <= e_cnt - E_ONE;
          end
        end
        ROUND: begin
          sign        <= sign_r;
          exponent    <= e_rnd;
          significand <= f_rnd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_seq.sv
// Self-checking bench for fp_convert_seq: table vectors, random vectors against a reference
// model, and hand-written stall / throughput / mid-operation reset sequences.
module tb_fp_convert_seq;

  localparam int IN_W = 12;
  localparam int EXP_W = 3;
  localparam int MANT_W = 4;
  localparam int RW = 1 + EXP_W + MANT_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   din;
  logic              out_valid;
  logic              out_ready;
  logic              sign;
  logic [EXP_W-1:0]  exponent;
  logic [MANT_W-1:0] significand;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  fp_convert_seq #(.IN_W(IN_W), .EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .exponent(exponent),
    .significand(significand)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IN_W-1:0] din;
    logic [RW-1:0]   res;
    int              lat;
  } vec_t;

  function automatic logic [RW-1:0] model(input logic [IN_W-1:0] d, output int n);
    int v;
    int e;
    logic [10:0] m;
    logic [3:0] f;
    v = $signed(d);
    if (v < 0) v = -v;
    if (v > 2047) v = 2047;
    m = 11'(v);
    e = 7;
    n = 0;
    while (e > 0 && !m[10]) begin
      m = m << 1;
      e--;
      n++;
    end
    f = m[10:7];
`ifdef FPCVT_ROUND_EN
    if (m[6]) begin
      if (f == 4'hF) begin
        if (e != 7) begin
          f = 4'h8;
          e++;
        end
      end else begin
        f = f + 4'h1;
      end
    end
`endif
    return {d[11], 3'(e), f};
  endfunction

  // scoreboard: compare each result on the cycle it is taken
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected result %h, nothing expected", {sign, exponent, significand});
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        if ({sign, exponent, significand} !== e) begin
          errors++;
          $display("FAIL scoreboard: got s/e/f %h expected %h", {sign, exponent, significand}, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // driver: called at a negedge; returns at a negedge with the converter idle
  task automatic send(input logic [IN_W-1:0] d, input logic [RW-1:0] res, input int exp_lat);
    int waits;
    int cnt;
    in_valid = 1'b1;
    din = d;
    waits = 0;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(res);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 60) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("latency", 32'(cnt), 32'(exp_lat));
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(in_ready && !out_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 32'(in_ready && !out_valid), 32'd1);
  endtask

  initial begin
    vec_t vecs[10];
    int   n;
    int   cnt;
    int   acc[$];
    logic [IN_W-1:0] r;
    logic [RW-1:0] stall_exp;

    vecs[0] = '{12'h000, 8'h00, 11};
`ifdef FPCVT_ROUND_EN
    vecs[1] = '{12'hE2A, 8'hDF, 6};
    vecs[2] = '{12'h07D, 8'h48, 8};
    vecs[4] = '{12'h06C, 8'h3E, 8};
`else
    vecs[1] = '{12'hE2A, 8'hDE, 6};
    vecs[2] = '{12'h07D, 8'h3F, 8};
    vecs[4] = '{12'h06C, 8'h3D, 8};
`endif
    vecs[3] = '{12'h800, 8'hFF, 4};
    vecs[5] = '{12'h7FF, 8'h7F, 4};
    vecs[6] = '{12'h001, 8'h01, 11};
    vecs[7] = '{12'hFFF, 8'h81, 11};
    vecs[8] = '{12'h400, 8'h78, 4};
    vecs[9] = '{12'h801, 8'hFF, 4};

    rst = 1'b1;
    in_valid = 1'b0;
    din = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'({sign, exponent, significand}), 32'd0);

    for (int i = 0; i < 10; i++) send(vecs[i].din, vecs[i].res, vecs[i].lat);

    for (int i = 0; i < 16; i++) begin
      logic [RW-1:0] m;
      r = 12'($urandom_range(0, 4095));
      m = model(r, n);
      send(r, m, n + 4);
    end

    // throughput: in_valid held high, accepts every n+5 cycles
    in_valid = 1'b1;
    din = 12'h7FF;
    for (int k = 0; k < 40 && acc.size() < 2; k++) begin
      if (in_ready) begin
        acc.push_back(k);
        exp_q.push_back(8'h7F);
      end
      @(posedge clk);
      #1 if (acc.size() == 2) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("throughput_accepts", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) check("throughput_period", 32'(acc[1] - acc[0]), 32'd5);
    wait_idle();

    // stall: result held while out_ready is low, next input waits
    stall_exp = vecs[4].res;
    out_ready = 1'b0;
    in_valid = 1'b1;
    din = 12'h06C;
    exp_q.push_back(stall_exp);
    @(posedge clk);
    #1 din = 12'h7FF;
    cnt = 0;
    while (!out_valid && cnt < 60) begin
      @(posedge clk);
      #1 cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_result", 32'({sign, exponent, significand}), 32'(stall_exp));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 check("stall_release_in_ready", 32'(in_ready), 32'd1);
    check("stall_release_out_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(8'h7F);
    @(posedge clk);
    #1 check("stall_next_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    wait_idle();

    // reset during NORM abandons the conversion
    in_valid = 1'b1;
    din = 12'h000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'({sign, exponent, significand}), 32'd0);
    @(negedge clk);
    send(vecs[1].din, vecs[1].res, vecs[1].lat);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
